// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; per-word parity mode, stop-bit count and err are captured at push.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN (adds the send_break port).
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef UART_TX_BREAK_EN
    input  logic                          send_break,
`endif
    input  logic                          valid,
    input  logic [DATA_WIDTH-1:0]         input_tx,
    input  logic                          err,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          ready,
    output logic                          Tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int EW = DATA_WIDTH + 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // err flips the computed bit so a receiver sees a deliberately bad frame
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic [1:0] mode, input logic e);
        logic p;
        p = ^d;
        if (mode == 2'b10) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p ^ e;
    endfunction

    logic [EW-1:0]         mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  push_s, pop_s, load_s, brk_s, bit_end_s;
    logic [EW-1:0]         head_s;

    state_t                state_r, state_n;
    logic [BW-1:0]         bit_cnt_r, bit_cnt_n;
    logic [IW-1:0]         idx_r, idx_n;
    logic [DATA_WIDTH-1:0] shift_r, shift_n;
    logic                  par_bit_r, par_bit_n, par_en_r, par_en_n;
    logic                  two_stop_r, two_stop_n, stop2_r, stop2_n;
    logic                  tx_r, tx_n, busy_r, busy_n;
    logic                  brk_r, brk_n, wait_r, wait_n;

`ifdef UART_TX_BREAK_EN
    assign brk_s = send_break;
`else
    assign brk_s = 1'b0;
`endif

    assign ready      = (count_r < CW'(FIFO_DEPTH));
    assign push_s     = valid && ready;
    assign head_s     = mem_r[rd_ptr_r];
    assign bit_end_s  = (bit_cnt_r == BW'(CLKS_PER_BIT - 1));
    assign Tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {err, parity_mode, two_stop, input_tx};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state and next-output logic of the framing FSM
    always_comb begin
        state_n    = state_r;
        bit_cnt_n  = bit_cnt_r;
        idx_n      = idx_r;
        shift_n    = shift_r;
        par_bit_n  = par_bit_r;
        par_en_n   = par_en_r;
        two_stop_n = two_stop_r;
        stop2_n    = stop2_r;
        tx_n       = tx_r;
        busy_n     = busy_r;
        brk_n      = brk_r;
        wait_n     = wait_r;
        load_s     = 1'b0;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (brk_s) begin
                    tx_n   = 1'b0;
                    busy_n = 1'b1;
                    brk_n  = 1'b1;
                    wait_n = 1'b0;
                end else if (brk_r) begin
                    // a released break owes the line one full idle bit period
                    tx_n      = 1'b1;
                    busy_n    = 1'b0;
                    brk_n     = 1'b0;
                    wait_n    = 1'b1;
                    bit_cnt_n = BW'(0);
                end else if (wait_r) begin
                    if (bit_end_s) begin
                        wait_n = 1'b0;
                        load_s = (count_r != CW'(0));
                    end else begin
                        bit_cnt_n = bit_cnt_r + BW'(1);
                    end
                end else if (count_r != CW'(0)) begin
                    load_s = 1'b1;
                end else begin
                    tx_n   = 1'b1;
                    busy_n = 1'b0;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_n   = DATA;
                    bit_cnt_n = BW'(0);
                    idx_n     = IW'(0);
                    tx_n      = shift_r[0];
                    shift_n   = shift_r >> 1;
                end else begin
                    bit_cnt_n = bit_cnt_r + BW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    bit_cnt_n = BW'(0);
                    if (idx_r == IW'(DATA_WIDTH - 1)) begin
                        state_n = par_en_r ? PARITY : STOP;
                        tx_n    = par_en_r ? par_bit_r : 1'b1;
                        stop2_n = 1'b0;
                    end else begin
                        idx_n   = idx_r + IW'(1);
                        tx_n    = shift_r[0];
                        shift_n = shift_r >> 1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt_r + BW'(1);
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_n   = STOP;
                    bit_cnt_n = BW'(0);
                    tx_n      = 1'b1;
                    stop2_n   = 1'b0;
                end else begin
                    bit_cnt_n = bit_cnt_r + BW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    bit_cnt_n = BW'(0);
                    if (two_stop_r && !stop2_r) begin
                        stop2_n = 1'b1;
                    end else if (brk_s) begin
                        state_n = IDLE;
                        tx_n    = 1'b0;
                        busy_n  = 1'b1;
                        brk_n   = 1'b1;
                    end else if (count_r != CW'(0)) begin
                        load_s = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    bit_cnt_n = bit_cnt_r + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
        // pop the head word and start its frame without an idle gap
        if (load_s) begin
            pop_s      = 1'b1;
            shift_n    = head_s[DATA_WIDTH-1:0];
            two_stop_n = head_s[DATA_WIDTH];
            par_en_n   = parity_enabled(head_s[DATA_WIDTH+2:DATA_WIDTH+1]);
            par_bit_n  = parity_bit(head_s[DATA_WIDTH-1:0], head_s[DATA_WIDTH+2:DATA_WIDTH+1], head_s[DATA_WIDTH+3]);
            stop2_n    = 1'b0;
            state_n    = START;
            bit_cnt_n  = BW'(0);
            tx_n       = 1'b0;
            busy_n     = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= BW'(0);
            idx_r      <= IW'(0);
            shift_r    <= '0;
            par_bit_r  <= 1'b0;
            par_en_r   <= 1'b0;
            two_stop_r <= 1'b0;
            stop2_r    <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            brk_r      <= 1'b0;
            wait_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            idx_r      <= idx_n;
            shift_r    <= shift_n;
            par_bit_r  <= par_bit_n;
            par_en_r   <= par_en_n;
            two_stop_r <= two_stop_n;
            stop2_r    <= stop2_n;
            tx_r       <= tx_n;
            busy_r     <= busy_n;
            brk_r      <= brk_n;
            wait_r     <= wait_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DATA_WIDTH=8, FIFO_DEPTH=4, CLKS_PER_BIT=4.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] input_tx;
    logic       err;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
`ifdef UART_TX_BREAK_EN
    logic       send_break = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef UART_TX_BREAK_EN
        .send_break  (send_break),
`endif
        .valid       (valid),
        .input_tx    (input_tx),
        .err         (err),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .ready       (ready),
        .Tx          (tx),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level c cycles after the first start-bit cycle, 4 clocks per bit
    function automatic logic exp_bit(input logic [7:0] d, input bit pen, input bit pbit, input int c);
        int seg;
        seg = c / 4;
        if (seg == 0) return 1'b0;
        else if (seg <= 8) return d[seg-1];
        else if (pen && seg == 9) return pbit;
        else return 1'b1;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] d, input bit pen, input bit pbit,
                               input int nstop, input int skip);
        int len;
        len = 4 * (9 + (pen ? 1 : 0) + nstop);
        for (int c = skip; c < len; c++) begin
            tick();
            chk($sformatf("%s_c%0d_tx", tag, c), 32'(tx), 32'(exp_bit(d, pen, pbit, c)));
            chk($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'd1);
        end
    endtask

    task automatic idle_chk(input string tag);
        tick();
        chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_cnt"}, 32'(fifo_count), 32'd0);
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] m, input logic e, input logic t);
        valid       = 1'b1;
        input_tx    = d;
        parity_mode = m;
        err         = e;
        two_stop    = t;
        tick();
        valid       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; input_tx = 8'h00; err = 1'b0; parity_mode = 2'b00; two_stop = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        tick(); tick();
        reset = 1'b1;
        tick();

        // basic frame 0xA5, no parity, one stop: 40 cycles busy
        push(8'hA5, 2'b00, 1'b0, 1'b0);
        chk("a5_cnt_after_push", 32'(fifo_count), 32'd1);
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 1, 0);
        idle_chk("a5");

        // parity modes on 0x07 (three ones)
        push(8'h07, 2'b01, 1'b0, 1'b0);
        check_frame("even", 8'h07, 1'b1, 1'b1, 1, 0);
        idle_chk("even");
        push(8'h07, 2'b10, 1'b0, 1'b0);
        check_frame("odd", 8'h07, 1'b1, 1'b0, 1, 0);
        idle_chk("odd");
        push(8'h07, 2'b01, 1'b1, 1'b0);
        check_frame("even_err", 8'h07, 1'b1, 1'b0, 1, 0);
        idle_chk("even_err");

        // six back-to-back valids: first word pops at once, 0x66 is refused
        parity_mode = 2'b00; two_stop = 1'b0; err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid    = 1'b1;
            input_tx = words[i];
            tick();
            chk($sformatf("burst%0d_cnt", i), 32'(fifo_count), 32'(exp_cnt[i]));
            chk($sformatf("burst%0d_ready", i), 32'(ready), 32'(exp_rdy[i]));
            if (i >= 1) chk($sformatf("burst%0d_tx", i), 32'(tx), 32'(exp_bit(8'h11, 1'b0, 1'b0, i - 1)));
        end
        valid = 1'b0;
        check_frame("w11", 8'h11, 1'b0, 1'b0, 1, 5);
        check_frame("w22", 8'h22, 1'b0, 1'b0, 1, 0);
        check_frame("w33", 8'h33, 1'b0, 1'b0, 1, 0);
        check_frame("w44", 8'h44, 1'b0, 1'b0, 1, 0);
        check_frame("w55", 8'h55, 1'b0, 1'b0, 1, 0);
        idle_chk("burst");

        // two stop bits, two words queued, config inputs changed mid-frame
        push(8'h3C, 2'b00, 1'b0, 1'b1);
        push(8'hC3, 2'b00, 1'b0, 1'b1);
        chk("ts_first_start", 32'(tx), 32'd0);
        chk("ts_cnt", 32'(fifo_count), 32'd1);
        parity_mode = 2'b01; two_stop = 1'b0; err = 1'b1;
        check_frame("ts3c", 8'h3C, 1'b0, 1'b0, 2, 1);
        check_frame("tsc3", 8'hC3, 1'b0, 1'b0, 2, 0);
        idle_chk("ts");

        // reset during data bit 3 with two words still queued
        push(8'h96, 2'b00, 1'b0, 1'b0);
        push(8'h69, 2'b00, 1'b0, 1'b0);
        push(8'hF0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_cnt", 32'(fifo_count), 32'd2);
        chk("mid_tx_bit3", 32'(tx), 32'(exp_bit(8'h96, 1'b0, 1'b0, 17)));
        reset = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_cnt", 32'(fifo_count), 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd1);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("post_rst%0d_tx", i), 32'(tx), 32'd1);
            chk($sformatf("post_rst%0d_busy", i), 32'(busy), 32'd0);
        end
        push(8'h5A, 2'b10, 1'b0, 1'b0);
        check_frame("post_5a", 8'h5A, 1'b1, 1'b1, 1, 0);
        idle_chk("post_5a");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in input FIFO; successor to Tx_path.
- Generalises data width, bit timing and buffering.
- Adds runtime-selectable parity mode (none/even/odd) and 1 or 2 stop bits.
- Keeps the err parity-corruption hook.
- Sits between the host-side valid/ready producer and the serial line pin.

Parameters:
- DATA_WIDTH, 8: data bits per frame, 5..32.
- FIFO_DEPTH, 4: FIFO entries; power of two, >=2.
- CLKS_PER_BIT, 16: clock cycles per serial bit period, >=2.

Ports:
- clk  input  1: single clock, all logic rising-edge.
- reset  input  1: asynchronous, active-low reset.
- valid  input  1: producer has a word on input_tx.
- input_tx  input  DATA_WIDTH: word to transmit, LSB sent first.
- err  input  1: captured with the word; inverts that frame's parity bit.
- parity_mode  input  2: 00 none, 01 even, 10 odd, 11 none.
- two_stop  input  1: 0 = one stop bit, 1 = two stop bits.
- ready  output  1: FIFO can accept a word this cycle.
- Tx  output  1: serial line, registered, idle high.
- busy  output  1: a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1: entries held.

Behaviour:
- Reset (asynchronous, while reset=0):
  - Tx=1, busy=0, fifo_count=0, ready=1.
  - FSM returns to IDLE; FIFO pointers are cleared; a frame in flight is abandoned immediately.
- FIFO push:
  - Push on a rising edge with valid&&ready.
  - Each entry stores {err, parity_mode, two_stop, input_tx}, so configuration is captured per word at push time.
  - ready = (fifo_count < FIFO_DEPTH), combinational from count only; it does not look ahead to a same-cycle pop.
- Simultaneous push and pop: fifo_count is unchanged; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - A bit counter runs 0..CLKS_PER_BIT-1 per bit; a data index runs 0..DATA_WIDTH-1.
- IDLE:
  - Tx=1, busy=0.
  - If the FIFO is non-empty: pop, latch the entry, Tx<=0, busy<=1, go to START.
  - Latency: a word pushed at edge k into an empty, idle block drives Tx low from edge k+1.
- START: holds Tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
- DATA:
  - Sends data[i], LSB first, each bit for CLKS_PER_BIT cycles.
  - After the MSB, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Even mode sends ^data; odd mode sends ~^data.
  - The bit is XORed with the latched err.
  - Held for CLKS_PER_BIT cycles.
- STOP:
  - Tx=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT when the latched two_stop is set.
  - On the final cycle: if the FIFO is non-empty, pop and go straight to START (Tx<=0), giving no idle gap between frames. Otherwise go to IDLE with busy<=0.
- Frame length in cycles: CLKS_PER_BIT*(1+DATA_WIDTH+P+S), where P is 0 or 1 and S is 1 or 2.
- Config-input changes mid-frame have no effect on the current frame.
- Push while transmitting is allowed; only the FIFO is affected.
- The FIFO is never popped when empty; no underflow or overflow state exists.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port send_break (1 bit).
  - While send_break=1 and the FSM is in IDLE, or reaches IDLE after completing the current frame, Tx is held 0, busy=1, and no pop occurs.
  - On deassertion, Tx<=1 and the FSM holds one full bit period of idle before any pop.
- Undefined: the port is absent and the FSM behaves exactly as above.

Test Plan:
1. DATA_WIDTH=8, CLKS_PER_BIT=4, parity 00, two_stop=0; push 0xA5 at edge k -> Tx=0 at edges k+1..k+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; busy high exactly 40 cycles.
2. Parity: 0x07 with parity_mode=01 -> parity bit 1; with 10 -> 0; with 01 and err=1 -> 0; frame 44 cycles.
3. FIFO_DEPTH=4; hold valid for 6 consecutive cycles with idle line:
   - ready falls when fifo_count reaches 4.
   - Exactly the accepted words are transmitted in order.
   - Stop bit is immediately followed by the next start bit with no gap.
4. two_stop=1, two words queued -> Tx high for exactly 8 cycles between frames; a config change mid-frame leaves the frame unchanged.
5. Reset pulled low during DATA bit 3 with 2 words queued -> Tx=1, busy=0, fifo_count=0 without a clock edge; after release, Tx stays 1 until a new push.
6. With UART_TX_BREAK_EN: assert send_break mid-frame -> the frame completes, then Tx=0 while asserted; on release, 4 idle cycles precede the next queued start bit.
